// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings used by the master-side arbiter and its helpers.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    typedef enum logic [1:0] {
        ARB_PARK     = 2'b00,
        ARB_OWN      = 2'b01,
        ARB_HANDOVER = 2'b10
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set bit of req scanning from ptr upward, wrapping.
module rr_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int MIDX_W      = 1
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [MIDX_W-1:0]      ptr,
    output logic [MIDX_W-1:0]      winner,
    output logic                   any_req
);

    logic [2*NUM_MASTERS-1:0] dbl;
    logic [NUM_MASTERS-1:0]   rot;
    int                       sum;

    always_comb begin
        dbl     = {req, req} >> ptr;
        rot     = dbl[NUM_MASTERS-1:0];
        winner  = '0;
        any_req = 1'b0;
        sum     = 0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!any_req && rot[i]) begin
                any_req = 1'b1;
                sum     = int'(ptr) + i;
                if (sum >= NUM_MASTERS) sum = sum - NUM_MASTERS;
                winner  = MIDX_W'(sum);
            end
        end
    end

endmodule

// File: rtl/ahb2apb_master_arbiter.sv
// Shares one ahb2apb_bridge slave port between several AHB-Lite masters with
// round-robin arbitration and a hold limit per owner.
//
//   state        | meaning
//   ARB_PARK     | owner not requesting, grant parked on last owner
//   ARB_OWN      | owner requesting and holding the bridge
//   ARB_HANDOVER | grant just moved; new owner's first address phase
module ahb2apb_master_arbiter
    import ahb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int MIDX_W      = 1,
    parameter int ADDRWIDTH   = 16,
    parameter int DATAWIDTH   = 32,
    parameter int MAX_HOLD    = 16
) (
    input  logic                             HCLK,
    input  logic                             HRESETn,
    input  logic [NUM_MASTERS-1:0]           M_HBUSREQ,
    input  logic [NUM_MASTERS*ADDRWIDTH-1:0] M_HADDR,
    input  logic [NUM_MASTERS*2-1:0]         M_HTRANS,
    input  logic [NUM_MASTERS-1:0]           M_HWRITE,
    input  logic [NUM_MASTERS*3-1:0]         M_HSIZE,
    input  logic [NUM_MASTERS*4-1:0]         M_HPROT,
    input  logic [NUM_MASTERS*DATAWIDTH-1:0] M_HWDATA,
    output logic [NUM_MASTERS-1:0]           M_HGRANT,
    output logic [MIDX_W-1:0]                HMASTER,
    output logic                             HREADY_M,
    output logic [DATAWIDTH-1:0]             HRDATA_M,
    output logic                             HRESP_M,
    output logic                             B_HSEL,
    output logic [ADDRWIDTH-1:0]             B_HADDR,
    output logic                             B_HWRITE,
    output logic [2:0]                       B_HSIZE,
    output logic [1:0]                       B_HTRANS,
    output logic [3:0]                       B_HPROT,
    output logic [DATAWIDTH-1:0]             B_HWDATA,
    output logic                             B_HREADY,
    input  logic                             B_HREADYOUT,
    input  logic [DATAWIDTH-1:0]             B_HRDATA,
    input  logic                             B_HRESP
);

    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    arb_state_t             state;
    logic [MIDX_W-1:0]      g;
    logic [MIDX_W-1:0]      rr_ptr;
    logic [MIDX_W-1:0]      data_owner;
    logic                   data_valid;
    logic [HOLD_W-1:0]      hold_cnt;

    logic [NUM_MASTERS-1:0] g_onehot;
    logic [NUM_MASTERS-1:0] arb_req;
    logic [1:0]             g_trans;
    logic                   g_req;
    logic                   other_req;
    logic                   burst_locked;
    logic                   rearb;
    logic                   change;
    logic [MIDX_W-1:0]      winner;
    logic [MIDX_W-1:0]      next_ptr;
    logic                   any_req;

    // Address phase from the grant register, write data from the registered data-phase owner.
    always_comb begin
        g_onehot = '0;
        g_trans  = HTRANS_IDLE;
        B_HADDR  = '0;
        B_HWRITE = 1'b0;
        B_HSIZE  = '0;
        B_HPROT  = '0;
        B_HWDATA = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (MIDX_W'(i) == g) begin
                g_onehot[i] = 1'b1;
                g_trans     = M_HTRANS[i*2 +: 2];
                B_HADDR     = M_HADDR[i*ADDRWIDTH +: ADDRWIDTH];
                B_HWRITE    = M_HWRITE[i];
                B_HSIZE     = M_HSIZE[i*3 +: 3];
                B_HPROT     = M_HPROT[i*4 +: 4];
            end
            if (MIDX_W'(i) == data_owner) begin
                B_HWDATA = M_HWDATA[i*DATAWIDTH +: DATAWIDTH];
            end
        end
    end

    assign B_HTRANS = g_trans;
    assign B_HSEL   = g_trans[1];
    assign B_HREADY = B_HREADYOUT;
    assign HREADY_M = B_HREADYOUT;
    assign HRDATA_M = B_HRDATA;
    assign HRESP_M  = B_HRESP;
    assign M_HGRANT = g_onehot;
    assign HMASTER  = g;

    // The current owner is masked out so a hold-limit handover always moves the grant.
    assign arb_req      = M_HBUSREQ & ~g_onehot;
    assign g_req        = |(M_HBUSREQ & g_onehot);
    assign other_req    = |arb_req;
    assign burst_locked = (g_trans == HTRANS_SEQ) || (g_trans == HTRANS_BUSY);
    assign rearb        = (state != ARB_HANDOVER) && !burst_locked &&
                          (!g_req || ((hold_cnt == HOLD_LAST) && other_req));
    assign change       = rearb && any_req;
    assign next_ptr     = (winner == MIDX_W'(NUM_MASTERS - 1)) ? '0 : winner + 1'b1;

    rr_arbiter #(
        .NUM_MASTERS (NUM_MASTERS),
        .MIDX_W      (MIDX_W)
    ) u_rr_arbiter (
        .req     (arb_req),
        .ptr     (rr_ptr),
        .winner  (winner),
        .any_req (any_req)
    );

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state      <= ARB_PARK;
            g          <= '0;
            rr_ptr     <= '0;
            data_owner <= '0;
            data_valid <= 1'b0;
            hold_cnt   <= '0;
        end else if (B_HREADYOUT) begin
            data_owner <= g;
            data_valid <= g_trans[1];
            if (change) begin
                g        <= winner;
                rr_ptr   <= next_ptr;
                hold_cnt <= '0;
                state    <= ARB_HANDOVER;
            end else begin
                if (g_trans[1] && (hold_cnt != HOLD_LAST)) begin
                    hold_cnt <= hold_cnt + HOLD_W'(1);
                end
                state <= g_req ? ARB_OWN : ARB_PARK;
            end
        end
    end

endmodule

// File: tb/tb_ahb2apb_master_arbiter.sv
// Directed bench for the two-master arbiter with a hold limit of four.
module tb_ahb2apb_master_arbiter;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic [1:0]  M_HBUSREQ;
    logic [31:0] M_HADDR;
    logic [3:0]  M_HTRANS;
    logic [1:0]  M_HWRITE;
    logic [5:0]  M_HSIZE;
    logic [7:0]  M_HPROT;
    logic [63:0] M_HWDATA;
    logic [1:0]  M_HGRANT;
    logic        HMASTER;
    logic        HREADY_M;
    logic [31:0] HRDATA_M;
    logic        HRESP_M;
    logic        B_HSEL;
    logic [15:0] B_HADDR;
    logic        B_HWRITE;
    logic [2:0]  B_HSIZE;
    logic [1:0]  B_HTRANS;
    logic [3:0]  B_HPROT;
    logic [31:0] B_HWDATA;
    logic        B_HREADY;
    logic        B_HREADYOUT;
    logic [31:0] B_HRDATA;
    logic        B_HRESP;

    int checks = 0;
    int errors = 0;

    always #5 HCLK = ~HCLK;

    ahb2apb_master_arbiter #(
        .NUM_MASTERS (2),
        .MIDX_W      (1),
        .ADDRWIDTH   (16),
        .DATAWIDTH   (32),
        .MAX_HOLD    (4)
    ) dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .M_HBUSREQ   (M_HBUSREQ),
        .M_HADDR     (M_HADDR),
        .M_HTRANS    (M_HTRANS),
        .M_HWRITE    (M_HWRITE),
        .M_HSIZE     (M_HSIZE),
        .M_HPROT     (M_HPROT),
        .M_HWDATA    (M_HWDATA),
        .M_HGRANT    (M_HGRANT),
        .HMASTER     (HMASTER),
        .HREADY_M    (HREADY_M),
        .HRDATA_M    (HRDATA_M),
        .HRESP_M     (HRESP_M),
        .B_HSEL      (B_HSEL),
        .B_HADDR     (B_HADDR),
        .B_HWRITE    (B_HWRITE),
        .B_HSIZE     (B_HSIZE),
        .B_HTRANS    (B_HTRANS),
        .B_HPROT     (B_HPROT),
        .B_HWDATA    (B_HWDATA),
        .B_HREADY    (B_HREADY),
        .B_HREADYOUT (B_HREADYOUT),
        .B_HRDATA    (B_HRDATA),
        .B_HRESP     (B_HRESP)
    );

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  t0;
        logic [1:0]  t1;
        logic [1:0]  wr;
        logic        rdy;
        logic [1:0]  grant;
        logic        sel;
        logic [15:0] addr;
        logic        wrt;
        logic [31:0] wdata;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] req, input logic [1:0] t0, input logic [1:0] t1,
                         input logic [1:0] wr, input logic rdy);
        M_HBUSREQ   = req;
        M_HTRANS    = {t1, t0};
        M_HWRITE    = wr;
        B_HREADYOUT = rdy;
    endtask

    task automatic do_reset();
        HRESETn = 1'b0;
        drive(2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
        M_HADDR  = {16'h0010, 16'h1000};
        M_HWDATA = {32'hA5A5A5A5, 32'h11111111};
        repeat (2) @(posedge HCLK);
        #1 HRESETn = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge HCLK);
        #1;
    endtask

    initial begin
        M_HSIZE  = {3'b010, 3'b010};
        M_HPROT  = {4'h3, 4'h3};
        B_HRDATA = 32'h0;
        B_HRESP  = 1'b0;

        //            req    t0     t1     wr     rdy   grant  sel   addr      wrt   wdata
        vecs[0]  = '{2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 2'b01, 1'b0, 16'h1000, 1'b0, 32'h11111111};
        vecs[1]  = '{2'b10, 2'b00, 2'b10, 2'b10, 1'b1, 2'b01, 1'b0, 16'h1000, 1'b0, 32'h11111111};
        vecs[2]  = '{2'b10, 2'b00, 2'b10, 2'b10, 1'b1, 2'b10, 1'b1, 16'h0010, 1'b1, 32'h11111111};
        vecs[3]  = '{2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b10, 1'b0, 16'h0010, 1'b0, 32'hA5A5A5A5};
        vecs[4]  = '{2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 2'b10, 1'b0, 16'h0010, 1'b0, 32'hA5A5A5A5};
        vecs[5]  = '{2'b01, 2'b10, 2'b00, 2'b01, 1'b1, 2'b10, 1'b0, 16'h0010, 1'b0, 32'hA5A5A5A5};
        vecs[6]  = '{2'b01, 2'b10, 2'b00, 2'b01, 1'b1, 2'b01, 1'b1, 16'h1000, 1'b1, 32'hA5A5A5A5};
        vecs[7]  = '{2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 2'b01, 1'b0, 16'h1000, 1'b0, 32'h11111111};
        vecs[8]  = '{2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 2'b01, 1'b0, 16'h1000, 1'b0, 32'h11111111};
        vecs[9]  = '{2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 2'b01, 1'b0, 16'h1000, 1'b0, 32'h11111111};
        vecs[10] = '{2'b10, 2'b00, 2'b10, 2'b00, 1'b1, 2'b01, 1'b0, 16'h1000, 1'b0, 32'h11111111};
        vecs[11] = '{2'b10, 2'b00, 2'b10, 2'b00, 1'b1, 2'b10, 1'b1, 16'h0010, 1'b0, 32'h11111111};

        // Reset state with no requests
        do_reset();
        @(negedge HCLK);
        chk("rst_grant", M_HGRANT, 32'h1);
        chk("rst_hmaster", HMASTER, 32'h0);
        chk("rst_hsel", B_HSEL, 32'h0);
        next_cycle();

        // Single M1 write, bridge stall, M0 takeover, stall during M1 request
        for (int k = 0; k < 12; k++) begin
            drive(vecs[k].req, vecs[k].t0, vecs[k].t1, vecs[k].wr, vecs[k].rdy);
            B_HRDATA = 32'hD0000000 + k;
            B_HRESP  = k[0];
            @(negedge HCLK);
            chk($sformatf("v%0d_grant", k), M_HGRANT, vecs[k].grant);
            chk($sformatf("v%0d_hsel", k), B_HSEL, vecs[k].sel);
            chk($sformatf("v%0d_haddr", k), B_HADDR, vecs[k].addr);
            chk($sformatf("v%0d_hwrite", k), B_HWRITE, vecs[k].wrt);
            chk($sformatf("v%0d_hwdata", k), B_HWDATA, vecs[k].wdata);
            chk($sformatf("v%0d_hready", k), {HREADY_M, B_HREADY}, {vecs[k].rdy, vecs[k].rdy});
            chk($sformatf("v%0d_hrdata", k), HRDATA_M, 32'hD0000000 + k);
            chk($sformatf("v%0d_hresp", k), HRESP_M, k[0]);
            next_cycle();
        end

        // M0 write immediately followed by M1 read
        do_reset();
        M_HADDR = {16'h0020, 16'h1000};
        drive(2'b10, 2'b10, 2'b00, 2'b01, 1'b1);
        @(negedge HCLK);
        chk("wr_rd_m0_addr", B_HADDR, 32'h1000);
        next_cycle();
        drive(2'b00, 2'b00, 2'b10, 2'b00, 1'b1);
        @(negedge HCLK);
        chk("wr_rd_m1_addr", B_HADDR, 32'h0020);
        chk("wr_rd_m1_write", B_HWRITE, 32'h0);
        chk("wr_rd_m0_wdata", B_HWDATA, 32'h11111111);
        next_cycle();
        drive(2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
        B_HRDATA = 32'hCAFEF00D;
        @(negedge HCLK);
        chk("wr_rd_hrdata", HRDATA_M, 32'hCAFEF00D);
        next_cycle();

        // Both masters request continuously: four address phases each, alternating
        do_reset();
        drive(2'b11, 2'b10, 2'b10, 2'b00, 1'b1);
        for (int i = 0; i < 24; i++) begin
            @(negedge HCLK);
            chk($sformatf("rr_c%0d_hmaster", i), HMASTER, (i / 4) % 2);
            next_cycle();
        end

        // Single requester keeps the grant past the hold limit
        do_reset();
        drive(2'b01, 2'b10, 2'b00, 2'b00, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge HCLK);
            chk($sformatf("solo_c%0d_grant", i), M_HGRANT, 32'h1);
            next_cycle();
        end

        // Owner drops request mid-SEQ burst: grant held until IDLE
        do_reset();
        drive(2'b10, 2'b00, 2'b10, 2'b00, 1'b1);
        next_cycle();
        drive(2'b11, 2'b10, 2'b10, 2'b00, 1'b1);
        @(negedge HCLK);
        chk("seq_s1_grant", M_HGRANT, 32'h2);
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            drive(2'b01, 2'b10, 2'b11, 2'b00, 1'b1);
            @(negedge HCLK);
            chk($sformatf("seq_b%0d_grant", i), M_HGRANT, 32'h2);
            next_cycle();
        end
        drive(2'b01, 2'b10, 2'b00, 2'b00, 1'b1);
        @(negedge HCLK);
        chk("seq_idle_grant", M_HGRANT, 32'h2);
        next_cycle();
        @(negedge HCLK);
        chk("seq_after_grant", M_HGRANT, 32'h1);
        next_cycle();

        // Reset asserted during M1's data phase
        do_reset();
        drive(2'b10, 2'b00, 2'b10, 2'b10, 1'b1);
        next_cycle();
        next_cycle();
        drive(2'b01, 2'b10, 2'b00, 2'b01, 1'b0);
        @(negedge HCLK);
        chk("mid_rst_pre_hmaster", HMASTER, 32'h1);
        chk("mid_rst_pre_wdata", B_HWDATA, 32'hA5A5A5A5);
        #1 HRESETn = 1'b0;
        #1;
        chk("mid_rst_grant", M_HGRANT, 32'h1);
        chk("mid_rst_hmaster", HMASTER, 32'h0);
        chk("mid_rst_dvalid", dut.data_valid, 32'h0);
        chk("mid_rst_hsel", B_HSEL, 32'h1);
        chk("mid_rst_wdata", B_HWDATA, 32'h11111111);
        next_cycle();
        HRESETn = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
